axis_bit_corr_prog: RTL and testbench

Programmable, time-multiplexed bit (±1) correlator for NUM_PARALLEL sample channels and NUM_CORRS correlators. Coefficients are loaded at run time over a second AXI-stream port, so they are no longer fixed when the design is built. Each input beat is a new sample on every channel. For each correlator, the block emits one output beat carrying all NUM_PARALLEL results, with tdest set to the correlator index. The block sits between the channel distributor and the peak detector in the xcorr path.

---
 rtl/xcorr_pkg.sv | 19 +
 rtl/bit_dot_prod.sv | 26 ++
 rtl/axis_bit_corr_prog.sv | 89 ++++++++
 tb/tb_axis_bit_corr_prog.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/xcorr_pkg.sv
// xcorr_pkg: shared FSM encoding and arithmetic helpers for the xcorr path
package xcorr_pkg;
  typedef enum logic [1:0] {IDLE, CALC, OUT} state_t;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic signed [63:0] sext(input logic [63:0] v, input int w);
    return $signed(v << (64 - w)) >>> (64 - w);
  endfunction
  function automatic logic signed [63:0] sat(input logic signed [63:0] v, input int w);
    logic signed [63:0] hi, lo;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (w - 1));
    return v > hi ? hi : v < lo ? lo : v;
  endfunction
endpackage

// File: rtl/bit_dot_prod.sv
// bit_dot_prod: combinational signed +-1 dot product; clamps instead of wrapping under BIT_CORR_SAT_EN
module bit_dot_prod
  import xcorr_pkg::*;
#(
  parameter int WAVE_WIDTH  = 6,
  parameter int ADDER_WIDTH = 12,
  parameter int CORR_LENGTH = 16
) (
  input  logic [CORR_LENGTH*WAVE_WIDTH-1:0] hist,
  input  logic [CORR_LENGTH-1:0]            coef,
  output logic [ADDER_WIDTH-1:0]            y
);
  localparam int FW = ADDER_WIDTH + clog2(CORR_LENGTH) + 1;
  logic signed [FW-1:0] acc;
  always_comb begin
    acc = '0;
    for (int k = 0; k < CORR_LENGTH; k++)
      acc = coef[k] ? acc + FW'(sext(64'(hist[k*WAVE_WIDTH +: WAVE_WIDTH]), WAVE_WIDTH))
                    : acc - FW'(sext(64'(hist[k*WAVE_WIDTH +: WAVE_WIDTH]), WAVE_WIDTH));
  end
`ifdef BIT_CORR_SAT_EN
  assign y = ADDER_WIDTH'(sat(64'(acc), ADDER_WIDTH));
`else
  assign y = ADDER_WIDTH'(acc);
`endif
endmodule

// File: rtl/axis_bit_corr_prog.sv
// axis_bit_corr_prog: time-multiplexed programmable bit correlator, one channel per cycle
// Optional BIT_CORR_SAT_EN selects saturating instead of wrapping results.
module axis_bit_corr_prog
  import xcorr_pkg::*;
#(
  parameter int NUM_PARALLEL = 8,
  parameter int WAVE_WIDTH   = 6,
  parameter int ADDER_WIDTH  = 12,
  parameter int NUM_CORRS    = 2,
  parameter int CORR_LENGTH  = 16,
  parameter logic [NUM_CORRS*CORR_LENGTH-1:0] CORR_INIT = '0,
  parameter int NUM_CORRS_W  = (clog2(NUM_CORRS) < 1) ? 1 : clog2(NUM_CORRS)
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                s_axis_tvalid,
  output logic                                s_axis_tready,
  input  logic [WAVE_WIDTH*NUM_PARALLEL-1:0]  s_axis_tdata,
  input  logic                                s_coef_tvalid,
  output logic                                s_coef_tready,
  input  logic [CORR_LENGTH-1:0]              s_coef_tdata,
  input  logic [NUM_CORRS_W-1:0]              s_coef_tdest,
  output logic                                m_axis_tvalid,
  input  logic                                m_axis_tready,
  output logic [ADDER_WIDTH*NUM_PARALLEL-1:0] m_axis_tdata,
  output logic [NUM_CORRS_W-1:0]              m_axis_tdest
);
  localparam int CH_W = (clog2(NUM_PARALLEL) < 1) ? 1 : clog2(NUM_PARALLEL);
  localparam int HW = CORR_LENGTH * WAVE_WIDTH;
  state_t state, next;
  logic [CH_W-1:0] ch;
  logic [NUM_CORRS_W-1:0] corr;
  logic [HW-1:0] hist [NUM_PARALLEL];
  logic [CORR_LENGTH-1:0] coef [NUM_CORRS];
  logic [ADDER_WIDTH*NUM_PARALLEL-1:0] res;
  logic [ADDER_WIDTH-1:0] y;
  logic s_fire, c_fire, m_fire, last_ch, last_corr;
  assign s_coef_tready = state == IDLE;
  assign s_axis_tready = state == IDLE && !s_coef_tvalid;
  assign m_axis_tvalid = state == OUT;
  assign m_axis_tdata = res;
  assign m_axis_tdest = corr;
  assign s_fire = s_axis_tvalid && s_axis_tready;
  assign c_fire = s_coef_tvalid && s_coef_tready;
  assign m_fire = m_axis_tvalid && m_axis_tready;
  assign last_ch = ch == CH_W'(NUM_PARALLEL - 1);
  assign last_corr = corr == NUM_CORRS_W'(NUM_CORRS - 1);
  bit_dot_prod #(
    .WAVE_WIDTH (WAVE_WIDTH),
    .ADDER_WIDTH(ADDER_WIDTH),
    .CORR_LENGTH(CORR_LENGTH)
  ) u_dot (
    .hist(hist[ch]),
    .coef(coef[corr]),
    .y   (y)
  );
  always_comb begin
    next = state == IDLE ? (s_fire ? CALC : IDLE)
         : state == CALC ? (last_ch ? OUT : CALC)
         : m_fire ? (last_corr ? IDLE : CALC) : OUT;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ch <= '0;
      corr <= '0;
      res <= '0;
      for (int n = 0; n < NUM_PARALLEL; n++) hist[n] <= '0;
      for (int j = 0; j < NUM_CORRS; j++) coef[j] <= CORR_INIT[j*CORR_LENGTH +: CORR_LENGTH];
    end else begin
      state <= next;
      if (c_fire && 32'(s_coef_tdest) < NUM_CORRS) coef[s_coef_tdest] <= s_coef_tdata;
      if (s_fire) begin
        for (int n = 0; n < NUM_PARALLEL; n++)
          hist[n] <= HW'({hist[n], s_axis_tdata[n*WAVE_WIDTH +: WAVE_WIDTH]});
        ch <= '0;
        corr <= '0;
      end
      if (state == CALC) begin
        res[ch*ADDER_WIDTH +: ADDER_WIDTH] <= y;
        ch <= ch + 1'b1;
      end
      if (m_fire && !last_corr) begin
        corr <= corr + 1'b1;
        ch <= '0;
      end
    end
  end
endmodule

// File: tb/tb_axis_bit_corr_prog.sv
// tb_axis_bit_corr_prog: directed + random checks against a sum-of-products model
// Expected results follow BIT_CORR_SAT_EN (clamp) or its absence (wrap).
module tb_axis_bit_corr_prog;
  localparam int NP = 2, L = 4, NC = 2, W = 6, AW = 12;
  localparam int NC2 = 3, AW2 = 6;
  logic clk, rst;
  logic s_axis_tvalid, s_axis_tready, s_coef_tvalid, s_coef_tready;
  logic [W*NP-1:0] s_axis_tdata;
  logic [L-1:0] s_coef_tdata;
  logic [0:0] s_coef_tdest, m_axis_tdest;
  logic m_axis_tvalid, m_axis_tready;
  logic [AW*NP-1:0] m_axis_tdata;
  logic b_tvalid, b_tready, b_cvalid, b_cready, b_mvalid, b_mready;
  logic [W*NP-1:0] b_tdata;
  logic [L-1:0] b_cdata;
  logic [1:0] b_cdest, b_mdest;
  logic [AW2*NP-1:0] b_mdata;
  int total, bad;
  int mh [NP][L];
  bit [L-1:0] mc [NC];
  int bh [NP][L];
  bit [L-1:0] bc [NC2];
  logic [AW*NP-1:0] snap;

  axis_bit_corr_prog #(.NUM_PARALLEL(NP), .WAVE_WIDTH(W), .ADDER_WIDTH(AW), .NUM_CORRS(NC),
                       .CORR_LENGTH(L)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
    .s_coef_tvalid(s_coef_tvalid), .s_coef_tready(s_coef_tready), .s_coef_tdata(s_coef_tdata),
    .s_coef_tdest(s_coef_tdest),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
    .m_axis_tdest(m_axis_tdest));

  axis_bit_corr_prog #(.NUM_PARALLEL(NP), .WAVE_WIDTH(W), .ADDER_WIDTH(AW2), .NUM_CORRS(NC2),
                       .CORR_LENGTH(L)) dut_narrow (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(b_tvalid), .s_axis_tready(b_tready), .s_axis_tdata(b_tdata),
    .s_coef_tvalid(b_cvalid), .s_coef_tready(b_cready), .s_coef_tdata(b_cdata),
    .s_coef_tdest(b_cdest),
    .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready), .m_axis_tdata(b_mdata),
    .m_axis_tdest(b_mdest));

  initial clk = 0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int fit(input int s, input int aw);
    int m, r;
    m = 1 << aw;
`ifdef BIT_CORR_SAT_EN
    r = s > m / 2 - 1 ? m / 2 - 1 : s < -m / 2 ? -m / 2 : s;
`else
    r = s % m;
    if (r < 0) r += m;
    if (r >= m / 2) r -= m;
`endif
    return r;
  endfunction

  function automatic int expy(input int j, input int n);
    int s = 0;
    for (int k = 0; k < L; k++) s += mc[j][k] ? mh[n][k] : -mh[n][k];
    return fit(s, AW);
  endfunction

  function automatic int expb(input int j, input int n);
    int s = 0;
    for (int k = 0; k < L; k++) s += bc[j][k] ? bh[n][k] : -bh[n][k];
    return fit(s, AW2);
  endfunction

  task automatic coef_write(input int dest, input logic [L-1:0] bits);
    int t = 0;
    @(negedge clk);
    s_coef_tvalid = 1; s_coef_tdest = dest[0:0]; s_coef_tdata = bits;
    #1;
    while (!s_coef_tready && t < 40) begin @(negedge clk); #1; t++; end
    chk("coef_handshake", t < 40, 1);
    @(posedge clk);
    mc[dest] = bits;
    #1 s_coef_tvalid = 0;
  endtask

  task automatic shift_model(input int x0, input int x1);
    for (int k = L - 1; k > 0; k--) begin mh[0][k] = mh[0][k-1]; mh[1][k] = mh[1][k-1]; end
    mh[0][0] = x0; mh[1][0] = x1;
  endtask

  task automatic send_beat(input int x0, input int x1);
    int t = 0;
    @(negedge clk);
    s_axis_tvalid = 1; s_axis_tdata = {6'(x1), 6'(x0)};
    #1;
    while (!s_axis_tready && t < 40) begin @(negedge clk); #1; t++; end
    chk("beat_handshake", t < 40, 1);
    @(posedge clk);
    shift_model(x0, x1);
    #1 s_axis_tvalid = 0;
  endtask

  task automatic collect(input bit stall);
    if (stall) m_axis_tready = 0;
    for (int j = 0; j < NC; j++) begin
      int t = 0;
      do begin @(negedge clk); t++; end while (!m_axis_tvalid && t < 40);
      chk($sformatf("latency_c%0d", j), t, NP + 1);
      chk($sformatf("tdest_c%0d", j), m_axis_tdest, j);
      for (int n = 0; n < NP; n++)
        chk($sformatf("y_c%0d_ch%0d", j, n), $signed(m_axis_tdata[n*AW +: AW]), expy(j, n));
      if (stall && j == 0) begin
        snap = m_axis_tdata;
        repeat (10) begin
          @(negedge clk);
          chk("stall_hold", {m_axis_tvalid, m_axis_tdata == snap, m_axis_tdest == 1'b0,
                             s_axis_tready, s_coef_tready}, 5'b11100);
        end
        m_axis_tready = 1;
      end
    end
    @(negedge clk);
    chk("ready_after_batch", s_axis_tready, 1);
  endtask

  task automatic b_coef(input int dest, input logic [L-1:0] bits);
    int t = 0;
    @(negedge clk);
    b_cvalid = 1; b_cdest = dest[1:0]; b_cdata = bits;
    #1;
    while (!b_cready && t < 40) begin @(negedge clk); #1; t++; end
    chk("narrow_coef_handshake", t < 40, 1);
    @(posedge clk);
    if (dest < NC2) bc[dest] = bits;
    #1 b_cvalid = 0;
  endtask

  task automatic b_beat(input int x0, input int x1);
    int t = 0;
    @(negedge clk);
    b_tvalid = 1; b_tdata = {6'(x1), 6'(x0)};
    #1;
    while (!b_tready && t < 40) begin @(negedge clk); #1; t++; end
    chk("narrow_beat_handshake", t < 40, 1);
    @(posedge clk);
    for (int k = L - 1; k > 0; k--) begin bh[0][k] = bh[0][k-1]; bh[1][k] = bh[1][k-1]; end
    bh[0][0] = x0; bh[1][0] = x1;
    #1 b_tvalid = 0;
    for (int j = 0; j < NC2; j++) begin
      t = 0;
      do begin @(negedge clk); t++; end while (!b_mvalid && t < 40);
      chk("narrow_valid", t < 40, 1);
      chk($sformatf("narrow_tdest_c%0d", j), b_mdest, j);
      for (int n = 0; n < NP; n++)
        chk($sformatf("narrow_y_c%0d_ch%0d", j, n), $signed(b_mdata[n*AW2 +: AW2]), expb(j, n));
    end
  endtask

  initial begin
    int t;
    total = 0; bad = 0;
    rst = 1; m_axis_tready = 1; s_axis_tvalid = 0; s_coef_tvalid = 0;
    s_axis_tdata = '0; s_coef_tdata = '0; s_coef_tdest = '0;
    b_tvalid = 0; b_cvalid = 0; b_mready = 1; b_tdata = '0; b_cdata = '0; b_cdest = '0;
    for (int n = 0; n < NP; n++) for (int k = 0; k < L; k++) begin mh[n][k] = 0; bh[n][k] = 0; end
    for (int j = 0; j < NC; j++) mc[j] = '0;
    for (int j = 0; j < NC2; j++) bc[j] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 0;
    chk("reset_state", {m_axis_tvalid, m_axis_tdest, s_axis_tready, s_coef_tready}, 4'b0011);
    chk("reset_tdata", m_axis_tdata, 0);

    coef_write(0, 4'b1111);
    repeat (4) begin send_beat(1, 0); collect(0); end

    coef_write(1, 4'b0101);
    send_beat(0, 5); collect(0);
    repeat (3) begin send_beat(0, 0); collect(0); end

    send_beat(int'($urandom_range(63)) - 32, int'($urandom_range(63)) - 32);
    collect(1);

    @(negedge clk);
    s_coef_tvalid = 1; s_coef_tdest = 1'b0; s_coef_tdata = 4'b0011;
    s_axis_tvalid = 1; s_axis_tdata = {6'(-3), 6'(7)};
    #1;
    chk("both_valid_sample_stalled", s_axis_tready, 0);
    chk("both_valid_coef_ready", s_coef_tready, 1);
    @(posedge clk);
    mc[0] = 4'b0011;
    #1 s_coef_tvalid = 0;
    @(negedge clk); #1;
    chk("sample_ready_after_coef", s_axis_tready, 1);
    @(posedge clk);
    shift_model(7, -3);
    #1 s_axis_tvalid = 0;
    collect(0);

    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(2) == 0) coef_write(int'($urandom_range(1)), 4'($urandom));
      send_beat(int'($urandom_range(63)) - 32, int'($urandom_range(63)) - 32);
      collect(0);
    end

    send_beat(3, 4);
    m_axis_tready = 0;
    t = 0;
    do begin @(negedge clk); t++; end while (!m_axis_tvalid && t < 40);
    chk("reset_mid_out_reach", m_axis_tvalid, 1);
    rst = 1;
    @(negedge clk);
    chk("reset_mid_out_state", {m_axis_tvalid, m_axis_tdest, s_axis_tready, s_coef_tready}, 4'b0011);
    chk("reset_mid_out_tdata", m_axis_tdata, 0);
    rst = 0;
    m_axis_tready = 1;
    for (int n = 0; n < NP; n++) for (int k = 0; k < L; k++) mh[n][k] = 0;
    for (int j = 0; j < NC; j++) mc[j] = '0;
    send_beat(0, 9); collect(0);

    b_coef(0, 4'b1111);
    b_coef(3, 4'b1010);
    b_coef(2, 4'b1100);
    repeat (4) b_beat(31, 0);
    chk("narrow_final_c0", $signed(b_mdata[AW2-1:0]) == -6'sd1 ? 0 : 1, 1);
    b_beat(0, -17);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
